brownout_rate_monitor: RTL and testbench

BROWNOUT_RATE_MONITOR -- requirements
Module: brownout_rate_monitor

---
 rtl/brownout_rate_monitor.sv | 186 ++++++++++++++++++
 tb/tb_brownout_rate_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/brownout_rate_monitor.sv
// Brownout monitor: trips on a critical detector or on a debounced run of excessive
// sample-to-sample drops, then holds the trip until a clean interval or an explicit clear.
module brownout_rate_monitor #(
    parameter int DATA_W      = 20,
    parameter int DEBOUNCE    = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] adc_in,
    input  logic [DATA_W-1:0] rate_limit,
    input  logic              bod_warn,
    input  logic              bod_crit,
    input  logic              clear,
    output logic              brownout,
    output logic [1:0]        trip_cause,
    output logic [DATA_W-1:0] drop_out,
    output logic [1:0]        state_out
);

    localparam int VW = (DEBOUNCE    < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [VW-1:0] DEB_MAX  = VW'(DEBOUNCE);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MONITOR = 2'b01,
        TRIP    = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic [VW-1:0]     viol_cnt_q, viol_cnt_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [1:0]        trip_cause_q, trip_cause_d;
    logic [DATA_W-1:0] drop_q, drop_d;
    logic              brownout_q, brownout_d;

    logic [DATA_W-1:0] drop_now;
    logic              violating;
    logic              rate_trip;
    logic              trip_exit;
    logic [VW-1:0]     viol_inc;
    logic [HW-1:0]     hold_inc;

    // Unsigned drop; a rise in the sample yields zero rather than wrapping.
    function automatic logic [DATA_W-1:0] calc_drop(input logic [DATA_W-1:0] prev,
                                                    input logic [DATA_W-1:0] cur);
        return (prev > cur) ? (prev - cur) : '0;
    endfunction

    function automatic logic [HW-1:0] sat_hold_inc(input logic [HW-1:0] c);
        return (c >= HOLD_MAX) ? HOLD_MAX : (c + 1'b1);
    endfunction

    function automatic logic [VW-1:0] sat_viol_inc(input logic [VW-1:0] c);
        return (c >= DEB_MAX) ? DEB_MAX : (c + 1'b1);
    endfunction

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        viol_cnt_d   = viol_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        trip_cause_d = trip_cause_q;
        drop_d       = drop_q;
        rate_trip    = 1'b0;
        trip_exit    = 1'b0;

        drop_now  = calc_drop(prev_q, adc_in);
        violating = sample_valid && prev_valid_q && (state_q != IDLE) && (drop_now > rate_limit);
        viol_inc  = sat_viol_inc(viol_cnt_q);
        hold_inc  = sat_hold_inc(hold_cnt_q);

        // prev and drop track valid samples in both MONITOR and TRIP
        if (sample_valid && (state_q != IDLE)) begin
            prev_d       = adc_in;
            prev_valid_d = 1'b1;
            if (prev_valid_q) begin
                drop_d = drop_now;
            end
        end

        case (state_q)
            IDLE: begin
                if (bod_crit) begin
                    state_d      = TRIP;
                    trip_cause_d = 2'b01;
                    hold_cnt_d   = '0;
                end else if (bod_warn) begin
                    state_d = MONITOR;
                end
            end

            MONITOR: begin
                if (sample_valid && prev_valid_q) begin
                    if (violating) begin
                        viol_cnt_d = viol_inc;
                        rate_trip  = (viol_inc >= DEB_MAX);
                    end else begin
                        viol_cnt_d = '0;
                    end
                end
                if (bod_crit || rate_trip) begin
                    state_d      = TRIP;
                    trip_cause_d = {rate_trip, bod_crit};
                    viol_cnt_d   = '0;
                    hold_cnt_d   = '0;
                end else if (!bod_warn) begin
                    state_d      = IDLE;
                    prev_valid_d = 1'b0;
                    viol_cnt_d   = '0;
                    hold_cnt_d   = '0;
                end
            end

            TRIP: begin
                if (bod_crit) begin
                    hold_cnt_d      = '0;
                    trip_cause_d[0] = 1'b1;
                end else if (violating) begin
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_inc;
                    trip_exit  = (hold_inc >= HOLD_MAX);
                end
                if (!bod_crit && clear) begin
                    trip_exit = 1'b1;
                end
                if (trip_exit) begin
                    trip_cause_d = 2'b00;
                    hold_cnt_d   = '0;
                    viol_cnt_d   = '0;
                    if (bod_warn) begin
                        state_d = MONITOR;
                    end else begin
                        state_d      = IDLE;
                        prev_valid_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d      = IDLE;
                prev_valid_d = 1'b0;
                viol_cnt_d   = '0;
                hold_cnt_d   = '0;
                trip_cause_d = 2'b00;
            end
        endcase

        brownout_d = (state_d == TRIP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            viol_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            trip_cause_q <= 2'b00;
            drop_q       <= '0;
            brownout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            viol_cnt_q   <= viol_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            trip_cause_q <= trip_cause_d;
            drop_q       <= drop_d;
            brownout_q   <= brownout_d;
        end
    end

    assign brownout   = brownout_q;
    assign trip_cause = trip_cause_q;
    assign drop_out   = drop_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_brownout_rate_monitor.sv
// Directed bench for brownout_rate_monitor with DEBOUNCE=2, HOLD_CYCLES=4, rate_limit=14.
module tb_brownout_rate_monitor;

    localparam int DATA_W = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sample_valid;
    logic [DATA_W-1:0] adc_in;
    logic [DATA_W-1:0] rate_limit;
    logic              bod_warn;
    logic              bod_crit;
    logic              clear;
    logic              brownout;
    logic [1:0]        trip_cause;
    logic [DATA_W-1:0] drop_out;
    logic [1:0]        state_out;

    int checks = 0;
    int errors = 0;

    brownout_rate_monitor #(
        .DATA_W(DATA_W),
        .DEBOUNCE(2),
        .HOLD_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sample_valid(sample_valid),
        .adc_in(adc_in),
        .rate_limit(rate_limit),
        .bod_warn(bod_warn),
        .bod_crit(bod_crit),
        .clear(clear),
        .brownout(brownout),
        .trip_cause(trip_cause),
        .drop_out(drop_out),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [DATA_W-1:0] v);
        sample_valid = 1'b1;
        adc_in       = v;
        step();
        sample_valid = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        adc_in       = '0;
        rate_limit   = 20'd14;
        bod_warn     = 1'b0;
        bod_crit     = 1'b0;
        clear        = 1'b0;

        #3;
        chk("rst_state", 32'(state_out), 32'h0);
        chk("rst_brownout", 32'(brownout), 32'h0);
        chk("rst_cause", 32'(trip_cause), 32'h0);
        chk("rst_drop", 32'(drop_out), 32'h0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_state", 32'(state_out), 32'h0);

        // Rate trip: 1000, 980, 960
        bod_warn = 1'b1;
        step();
        chk("idle_to_mon", 32'(state_out), 32'h1);
        sample(20'd1000);
        chk("first_load_drop", 32'(drop_out), 32'h0);
        sample(20'd980);
        chk("rate_drop1", 32'(drop_out), 32'd20);
        chk("rate_no_trip_yet", 32'(brownout), 32'h0);
        sample(20'd960);
        chk("rate_drop2", 32'(drop_out), 32'd20);
        chk("rate_trip_bo", 32'(brownout), 32'h1);
        chk("rate_trip_cause", 32'(trip_cause), 32'h2);
        chk("rate_trip_state", 32'(state_out), 32'h2);

        // clear ignored while bod_crit is high, then honoured
        clear    = 1'b1;
        bod_crit = 1'b1;
        step();
        chk("clear_crit_state", 32'(state_out), 32'h2);
        chk("clear_crit_cause", 32'(trip_cause), 32'h3);
        bod_crit = 1'b0;
        step();
        chk("clear_state", 32'(state_out), 32'h1);
        chk("clear_cause", 32'(trip_cause), 32'h0);
        chk("clear_bo", 32'(brownout), 32'h0);
        step();
        chk("clear_outside_trip", 32'(state_out), 32'h1);
        clear = 1'b0;

        // Debounce and equality boundary
        bod_warn = 1'b0;
        step();
        chk("mon_to_idle", 32'(state_out), 32'h0);
        bod_warn = 1'b1;
        step();
        sample(20'd1000);
        sample(20'd980);
        chk("deb_drop20", 32'(drop_out), 32'd20);
        sample(20'd966);
        chk("deb_drop14", 32'(drop_out), 32'd14);
        chk("deb_eq_state", 32'(state_out), 32'h1);
        sample(20'd950);
        chk("deb_drop16", 32'(drop_out), 32'd16);
        chk("deb_no_trip", 32'(state_out), 32'h1);
        sample(20'd1200);
        chk("deb_rise_drop", 32'(drop_out), 32'h0);
        sample(20'd1180);
        chk("deb_cnt1_state", 32'(state_out), 32'h1);
        step();
        chk("deb_hold_state", 32'(state_out), 32'h1);
        sample(20'd1160);
        chk("deb_trip_state", 32'(state_out), 32'h2);
        chk("deb_trip_cause", 32'(trip_cause), 32'h2);

        // Hold release to MONITOR after 4 clean clocks
        step();
        step();
        step();
        chk("hold3_bo", 32'(brownout), 32'h1);
        step();
        chk("hold4_state", 32'(state_out), 32'h1);
        chk("hold4_cause", 32'(trip_cause), 32'h0);

        // Critical pulse from IDLE, release to IDLE
        bod_warn = 1'b0;
        step();
        chk("crit_pre_idle", 32'(state_out), 32'h0);
        bod_crit = 1'b1;
        step();
        bod_crit = 1'b0;
        chk("crit_bo", 32'(brownout), 32'h1);
        chk("crit_cause", 32'(trip_cause), 32'h1);
        step();
        step();
        step();
        chk("crit_hold3", 32'(brownout), 32'h1);
        step();
        chk("crit_release_state", 32'(state_out), 32'h0);
        chk("crit_release_bo", 32'(brownout), 32'h0);

        // Full-width drop
        bod_warn = 1'b1;
        step();
        sample(20'hFFFFF);
        sample(20'h00000);
        chk("wide_drop", 32'(drop_out), 32'hFFFFF);
        chk("wide_state", 32'(state_out), 32'h1);

        // Rate and critical on the same edge: counter is at 1 from the wide drop
        sample_valid = 1'b1;
        adc_in       = 20'd0;
        step();
        chk("wide_cnt_cleared", 32'(state_out), 32'h1);
        sample(20'd100);
        sample(20'd80);
        chk("both_pre_state", 32'(state_out), 32'h1);
        bod_crit = 1'b1;
        sample(20'd60);
        bod_crit = 1'b0;
        chk("both_cause", 32'(trip_cause), 32'h3);
        chk("both_state", 32'(state_out), 32'h2);

        // Asynchronous reset mid-TRIP
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bo", 32'(brownout), 32'h0);
        chk("async_rst_state", 32'(state_out), 32'h0);
        chk("async_rst_cause", 32'(trip_cause), 32'h0);
        chk("async_rst_drop", 32'(drop_out), 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_mon", 32'(state_out), 32'h1);
        sample(20'd1000);
        chk("post_rst_load_only", 32'(drop_out), 32'h0);
        sample(20'd900);
        chk("post_rst_drop", 32'(drop_out), 32'd100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
